// File: rtl/relojes_ce_gen.sv
// relojes_ce_gen: lock-qualified multi-channel fractional clock-enable generator
module relojes_ce_gen #(
  parameter int CHANNELS = 4,
  parameter int ACC_W = 24,
  parameter int LOCK_CYCLES = 1024,
  parameter logic [CHANNELS*ACC_W-1:0] INIT_INC = {CHANNELS{24'h400000}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  output logic [CHANNELS-1:0] ce,
  output logic                ready,
  output logic [CHANNELS-1:0] pending
);
  localparam int CW = $clog2(LOCK_CYCLES + 1);
  typedef enum logic {WAIT_LOCK, RUN} state_t;
  state_t state, state_nx;
  logic lk_m, lk_s, run;
  logic [CW-1:0] lk_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
      lk_cnt <= '0;
      state <= WAIT_LOCK;
    end else begin
      lk_m <= pll_locked;
      lk_s <= lk_m;
      lk_cnt <= !lk_s ? '0 : lk_cnt == CW'(LOCK_CYCLES) ? lk_cnt : lk_cnt + 1'b1;
      state <= state_nx;
    end
  end
  always_comb begin
    state_nx = (lk_s && lk_cnt >= CW'(LOCK_CYCLES - 1)) ? RUN : WAIT_LOCK;
  end
  assign ready = state == RUN;
  // accumulate only while staying in RUN so acc and ce clear on the edge ready falls
  assign run = ready && lk_s;
  for (genvar i = 0; i < CHANNELS; i++) begin : ch
    logic [ACC_W-1:0] acc, inc, pend_inc, inc_eff;
    logic [ACC_W:0] sum;
    logic ce_r, pend_r, wr, apply;
    assign wr = cfg_we && cfg_ch == 4'(i);
    // a write on the apply edge supersedes the older pending value
    assign apply = pend_r && (ce_r || inc == '0 || !ready) && !wr;
    assign inc_eff = apply ? pend_inc : inc;
    assign sum = {1'b0, acc} + {1'b0, inc_eff};
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc <= '0;
        inc <= INIT_INC[i*ACC_W +: ACC_W];
        pend_inc <= '0;
        pend_r <= 1'b0;
        ce_r <= 1'b0;
      end else begin
        acc <= run ? sum[ACC_W-1:0] : '0;
        ce_r <= run && sum[ACC_W];
        if (apply) inc <= pend_inc;
        if (wr) pend_inc <= cfg_inc;
        pend_r <= wr || (pend_r && !apply);
      end
    end
    assign ce[i] = ce_r;
    assign pending[i] = pend_r;
  end
endmodule

// File: tb/tb_relojes_ce_gen.sv
// tb_relojes_ce_gen: directed self-checking bench for relojes_ce_gen
module tb_relojes_ce_gen;
  localparam int L = 16;
  logic clk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, cfg_we = 1'b0;
  logic [3:0] cfg_ch = '0;
  logic [23:0] cfg_inc = '0;
  logic [3:0] ce, pending;
  logic ready;
  int checks = 0, errors = 0;
  int cnt [4];

  always #5 clk = ~clk;

  relojes_ce_gen #(.CHANNELS(4), .ACC_W(24), .LOCK_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .ce(ce), .ready(ready), .pending(pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    cnt = '{default: 0};
    for (int k = 0; k < n; k++) begin
      tick();
      for (int c = 0; c < 4; c++) cnt[c] += int'(ce[c]);
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [23:0] v);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_inc = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_ce(input int ch);
    int k = 0;
    while (!ce[ch] && k < 40) begin
      tick();
      k++;
    end
    check($sformatf("wait_ce%0d", ch), 32'(ce[ch]), 1);
  endtask

  task automatic wait_applied(input int ch);
    int k = 0;
    while (pending[ch] && k < 40) begin
      tick();
      k++;
    end
    check($sformatf("applied%0d", ch), 32'(pending[ch]), 0);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_ce", 32'(ce), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_pending", 32'(pending), 0);
    rst_n = 1'b1;
    pll_locked = 1'b1;
    repeat (L + 1) tick();
    check("ready_early", 32'(ready), 0);
    tick();
    check("ready_rise", 32'(ready), 1);
    repeat (3) tick();
    check("ce_before_first", 32'(ce), 0);
    tick();
    check("ce_first", 32'(ce), 4'hF);
    run(40);
    check("quarter_ch0", 32'(cnt[0]), 10);
    check("quarter_ch3", 32'(cnt[3]), 10);

    wr(0, 24'h555555);
    check("pend_ch0", 32'(pending), 4'b0001);
    wait_applied(0);
    run(3000);
    check("third_ch0", 32'(cnt[0]), 1000);
    wr(0, 24'h000000);
    wait_applied(0);
    run(100);
    check("zero_ch0", 32'(cnt[0]), 0);

    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("glitch_ready_hold", 32'(ready), 1);
    tick();
    check("glitch_ready_fall", 32'(ready), 0);
    check("glitch_ce_off", 32'(ce), 0);
    run(L - 1);
    check("glitch_no_ce", 32'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 0);
    check("glitch_ready_early", 32'(ready), 0);
    tick();
    check("glitch_ready_back", 32'(ready), 1);

    wait_ce(1);
    tick();
    wr(1, 24'h800000);
    check("pend_ch1", 32'(pending), 4'b0010);
    repeat (2) tick();
    check("bound_ce1", 32'(ce[1]), 1);
    check("bound_pend1", 32'(pending[1]), 1);
    tick();
    check("applied_pend1", 32'(pending[1]), 0);
    tick();
    check("half_ce1", 32'(ce[1]), 1);
    run(20);
    check("half_ch1", 32'(cnt[1]), 10);
    wait_ce(1);
    wr(1, 24'h400000);
    check("oncyc_pend1", 32'(pending[1]), 1);
    check("oncyc_ce1", 32'(ce[1]), 0);
    tick();
    check("oncyc_bound_ce1", 32'(ce[1]), 1);
    check("oncyc_bound_pend1", 32'(pending[1]), 1);
    tick();
    check("oncyc_applied1", 32'(pending[1]), 0);
    run(40);
    check("requarter_ch1", 32'(cnt[1]), 10);

    wait_ce(2);
    tick();
    wr(2, 24'h200000);
    wr(2, 24'h800000);
    wr(5, 24'h100000);
    check("pend_ch2_only", 32'(pending), 4'b0100);
    wait_applied(2);
    run(40);
    check("last_wins_ch2", 32'(cnt[2]), 20);
    check("inv_ch0", 32'(cnt[0]), 0);
    check("inv_ch1", 32'(cnt[1]), 10);
    check("inv_ch3", 32'(cnt[3]), 10);

    wr(3, 24'h100000);
    check("pre_rst_pend", 32'(pending), 4'b1000);
    check("pre_rst_ready", 32'(ready), 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_ce", 32'(ce), 0);
    check("mid_rst_ready", 32'(ready), 0);
    check("mid_rst_pending", 32'(pending), 0);
    rst_n = 1'b1;
    repeat (L + 1) tick();
    check("relock_early", 32'(ready), 0);
    tick();
    check("relock_ready", 32'(ready), 1);
    repeat (3) tick();
    check("relock_ce_pre", 32'(ce), 0);
    tick();
    check("relock_ce_first", 32'(ce), 4'hF);
    run(40);
    check("init_ch0", 32'(cnt[0]), 10);
    check("init_ch1", 32'(cnt[1]), 10);
    check("init_ch2", 32'(cnt[2]), 10);
    check("init_ch3", 32'(cnt[3]), 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
